chip8_draw_engine: RTL and testbench

Sequencer that owns the CPU-side port of the Chip-8 framebuffer and executes the display opcodes CLS and DRW. It sits between the Chip-8 core and the framebuffer's CPU port: it takes one command at a time over a valid/ready handshake, fetches sprite bytes from main memory and performs read-XOR-write on framebuffer words. It reports pixel collision for VF. The display is 128x64, 1 bpp, stored as 512 x 16-bit words: address = {row[5:0], word[2:0]}, with word bit 15 as the leftmost pixel.

---
 rtl/chip8_fb_pkg.sv | 37 +++
 rtl/chip8_draw_engine_if.sv | 26 ++
 rtl/chip8_sprite_shifter.sv | 16 +
 rtl/chip8_draw_engine.sv | 191 +++++++++++++++++++
 tb/tb_chip8_draw_engine.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip8_fb_pkg.sv
// Shared definitions for the Chip-8 draw engine.
// Framebuffer geometry, command opcode encodings and the sequencer state set.
// Build option: SCHIP_SPRITE16_EN adds the two-fetch row states used for
// 16x16 sprites (cmd_n = 0).
package chip8_fb_pkg;

  localparam int FB_WORDS_PER_ROW = 8;
  localparam int FB_ROWS          = 64;
  localparam int FB_DEPTH         = 512;

  localparam logic OP_CLS = 1'b0;
  localparam logic OP_DRW = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
`ifdef SCHIP_SPRITE16_EN
    FETCH_HI,
    FETCH_LO,
`else
    FETCH,
`endif
    RDA,
    RDB,
    WRA,
    WRB,
    DONE
  } state_t;

  // First state of every sprite row.
`ifdef SCHIP_SPRITE16_EN
  localparam state_t FETCH_FIRST = FETCH_HI;
`else
  localparam state_t FETCH_FIRST = FETCH;
`endif

endpackage

// File: rtl/chip8_draw_engine_if.sv
// Command channel between the Chip-8 core (master) and the draw engine (slave).
// Ports: cmd_valid/cmd_ready handshake, cmd_op/x/y/n/i command fields,
// done completion pulse and collision (VF) result.
interface chip8_draw_engine_if #(
  parameter int MEM_AW = 12
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [6:0]        cmd_x;
  logic [5:0]        cmd_y;
  logic [3:0]        cmd_n;
  logic [MEM_AW-1:0] cmd_i;
  logic              done;
  logic              collision;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_i,
    input  cmd_ready, done, collision
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_n, cmd_i,
    output cmd_ready, done, collision
  );
endinterface

// File: rtl/chip8_sprite_shifter.sv
// Combinational sprite aligner.
// Places a 16-bit sprite row (leftmost pixel in bit 15) at pixel offset
// shift within a 32-bit window spanning framebuffer words A and B.
// Ports: bits (sprite row), shift (x[3:0]), mask_a (word A), mask_b (word B).
module chip8_sprite_shifter (
  input  logic [15:0] bits,
  input  logic [3:0]  shift,
  output logic [15:0] mask_a,
  output logic [15:0] mask_b
);
  logic [31:0] wide;

  assign wide   = {bits, 16'h0000} >> shift;
  assign mask_a = wide[31:16];
  assign mask_b = wide[15:0];
endmodule

// File: rtl/chip8_draw_engine.sv
// Chip-8 display sequencer: executes CLS and DRW on the CPU port of a
// 512 x 16-bit framebuffer (address = {row[5:0], word[2:0]}, bit 15 leftmost).
// Ports: clk, reset (sync, active-high); cmd (command interface, slave side);
// mem_rd/mem_addr/mem_data sprite byte reads (1-cycle latency);
// fbuf_en/fbuf_write/fbuf_addr/fbuf_in/fbuf_out framebuffer port (1-cycle read).
// Build option: SCHIP_SPRITE16_EN makes cmd_n = 0 draw a 16x16 sprite;
// without it cmd_n = 0 completes immediately with no bus traffic.
module chip8_draw_engine
  import chip8_fb_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  chip8_draw_engine_if.slave   cmd,
  output logic                 mem_rd,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic [7:0]           mem_data,
  output logic                 fbuf_en,
  output logic                 fbuf_write,
  output logic [8:0]           fbuf_addr,
  output logic [15:0]          fbuf_in,
  input  logic [15:0]          fbuf_out
);

  state_t state, state_nx;

  logic              ready;
  logic              done_pulse;
  logic              accept;
  logic              coll;
  logic [6:0]        x_q;
  logic [5:0]        y_q;
  logic [MEM_AW-1:0] i_q;
  logic [3:0]        row;
  logic [3:0]        last_row;
  logic [8:0]        clr_addr;
  logic [7:0]        sprite_hi;
  logic [15:0]       sprite_bits;
  logic [15:0]       old_a;
  logic [15:0]       old_b;
  logic [15:0]       mask_a;
  logic [15:0]       mask_b;
  logic [5:0]        pix_row;
  logic [2:0]        word_a;
  logic [2:0]        word_b;

`ifdef SCHIP_SPRITE16_EN
  logic [7:0]        sprite_lo;
  assign sprite_bits = {sprite_hi, sprite_lo};
`else
  assign sprite_bits = {sprite_hi, 8'h00};
`endif

  assign accept  = ready && cmd.cmd_valid;
  assign pix_row = y_q + 6'(row);
  assign word_a  = x_q[6:4];
  assign word_b  = word_a + 3'd1;

  assign cmd.cmd_ready = ready;
  assign cmd.done      = done_pulse;
  assign cmd.collision = coll;

  chip8_sprite_shifter u_shifter (
    .bits   (sprite_bits),
    .shift  (x_q[3:0]),
    .mask_a (mask_a),
    .mask_b (mask_b)
  );

  // Control: state and sticky collision flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      coll  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept)
        coll <= 1'b0;
      else if ((state == WRA) && |(old_a & mask_a))
        coll <= 1'b1;
      else if ((state == WRB) && |(old_b & mask_b))
        coll <= 1'b1;
    end
  end

  // Datapath: command latch, counters and captured read data.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q      <= cmd.cmd_x;
      y_q      <= cmd.cmd_y;
      i_q      <= cmd.cmd_i;
      last_row <= cmd.cmd_n - 4'd1;  // n = 0 wraps to 15 for 16-row sprites
      row      <= 4'd0;
      clr_addr <= 9'd0;
    end
    if (state == CLR) clr_addr <= clr_addr + 9'd1;
    if (state == WRB) row <= row + 4'd1;
`ifdef SCHIP_SPRITE16_EN
    if (state == FETCH_LO) sprite_hi <= mem_data;
    if (state == RDA)      sprite_lo <= mem_data;
`else
    if (state == RDA)      sprite_hi <= mem_data;
`endif
    if (state == RDB) old_a <= fbuf_out;
    if (state == WRA) old_b <= fbuf_out;
  end

  always_comb begin
    state_nx   = state;
    ready      = 1'b0;
    done_pulse = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    fbuf_en    = 1'b0;
    fbuf_write = 1'b0;
    fbuf_addr  = '0;
    fbuf_in    = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) begin
          if (cmd.cmd_op == OP_CLS)
            state_nx = CLR;
          else if (cmd.cmd_n == 4'd0)
`ifdef SCHIP_SPRITE16_EN
            state_nx = FETCH_FIRST;
`else
            state_nx = DONE;
`endif
          else
            state_nx = FETCH_FIRST;
        end
      end
      CLR: begin
        fbuf_en    = 1'b1;
        fbuf_write = 1'b1;
        fbuf_addr  = clr_addr;
        if (clr_addr == 9'(FB_DEPTH - 1)) state_nx = DONE;
      end
`ifdef SCHIP_SPRITE16_EN
      FETCH_HI: begin
        mem_rd   = 1'b1;
        mem_addr = i_q + MEM_AW'({row, 1'b0});
        state_nx = FETCH_LO;
      end
      FETCH_LO: begin
        mem_rd   = 1'b1;
        mem_addr = i_q + MEM_AW'({row, 1'b1});
        state_nx = RDA;
      end
`else
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = i_q + MEM_AW'(row);
        state_nx = RDA;
      end
`endif
      RDA: begin
        fbuf_en   = 1'b1;
        fbuf_addr = {pix_row, word_a};
        state_nx  = RDB;
      end
      RDB: begin
        fbuf_en   = 1'b1;
        fbuf_addr = {pix_row, word_b};
        state_nx  = WRA;
      end
      WRA: begin
        fbuf_en    = 1'b1;
        fbuf_write = 1'b1;
        fbuf_addr  = {pix_row, word_a};
        fbuf_in    = old_a ^ mask_a;
        state_nx   = WRB;
      end
      WRB: begin
        fbuf_en    = 1'b1;
        fbuf_write = 1'b1;
        fbuf_addr  = {pix_row, word_b};
        fbuf_in    = old_b ^ mask_b;
        state_nx   = (row == last_row) ? DONE : FETCH_FIRST;
      end
      DONE: begin
        done_pulse = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Self-checking bench for chip8_draw_engine: framebuffer and sprite memory
// models, a write scoreboard fed by a pixel-level reference model, and
// latency/collision/traffic checks per command.
`timescale 1ns/1ps
module tb_chip8_draw_engine;
  import chip8_fb_pkg::*;

  localparam int MEM_AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chip8_draw_engine_if #(.MEM_AW(MEM_AW)) cif ();

  logic              mem_rd;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              fbuf_en;
  logic              fbuf_write;
  logic [8:0]        fbuf_addr;
  logic [15:0]       fbuf_in;
  logic [15:0]       fbuf_out;

  chip8_draw_engine #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cif),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .fbuf_en    (fbuf_en),
    .fbuf_write (fbuf_write),
    .fbuf_addr  (fbuf_addr),
    .fbuf_in    (fbuf_in),
    .fbuf_out   (fbuf_out)
  );

  logic [7:0]  mem [4096];
  logic [15:0] ram [512];
  logic [15:0] mfb [512];
  logic        fill;

  always @(posedge clk) begin
    if (fill) begin
      for (int k = 0; k < 512; k++) ram[k] <= 16'hFFFF;
    end else if (fbuf_en) begin
      if (fbuf_write) ram[fbuf_addr] <= fbuf_in;
      else            fbuf_out <= ram[fbuf_addr];
    end
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  typedef struct packed {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  mem_cnt = 0;
  int  fb_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard and bus-quiet monitor.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (mem_rd)  mem_cnt++;
      if (fbuf_en) fb_cnt++;
      if (mem_rd || fbuf_en) check_eq("bus_quiet", 32'(mem_rd & fbuf_en), 0);
      if (fbuf_en && fbuf_write) begin
        if (exp_q.size() == 0) begin
          check_eq("wr_extra", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", 32'(fbuf_addr), 32'(e.a));
          check_eq("wr_data", 32'(fbuf_in), 32'(e.d));
        end
      end
    end
  end

  // Pixel-level reference: pushes expected writes and updates the model frame.
  task automatic model_cmd(input logic op, input logic [6:0] x, input logic [5:0] y,
                           input logic [3:0] n, input logic [11:0] i, input int max_rows,
                           output logic coll, output int rows, output int fetches);
    int w, r, j, col, wd, bt, prow, wa, wb, aa, ab;
    logic [15:0] bits, ma, mb, oa, ob;
    coll = 1'b0;
    rows = 0;
    fetches = 1;
    if (op == OP_CLS) begin
      for (int k = 0; k < 512; k++) begin
        exp_q.push_back('{a: 9'(k), d: 16'h0000});
        mfb[k] = 16'h0000;
      end
    end else begin
      rows = int'(n);
      w = 8;
`ifdef SCHIP_SPRITE16_EN
      if (n == 4'd0) begin
        rows = 16;
        w = 16;
        fetches = 2;
      end
`endif
      if (rows > max_rows) rows = max_rows;
      for (r = 0; r < rows; r++) begin
        if (w == 8) bits = {mem[(int'(i) + r) % 4096], 8'h00};
        else        bits = {mem[(int'(i) + 2*r) % 4096], mem[(int'(i) + 2*r + 1) % 4096]};
        prow = (int'(y) + r) % 64;
        wa = int'(x) / 16;
        wb = (wa + 1) % 8;
        ma = 16'h0;
        mb = 16'h0;
        for (j = 0; j < w; j++) begin
          if (bits[15-j]) begin
            col = (int'(x) + j) % 128;
            wd  = col / 16;
            bt  = 15 - (col % 16);
            if (wd == wa) ma[bt] = 1'b1;
            else          mb[bt] = 1'b1;
          end
        end
        aa = prow * 8 + wa;
        ab = prow * 8 + wb;
        oa = mfb[aa];
        ob = mfb[ab];
        if (((oa & ma) != 16'h0) || ((ob & mb) != 16'h0)) coll = 1'b1;
        mfb[aa] = oa ^ ma;
        exp_q.push_back('{a: 9'(aa), d: oa ^ ma});
        mfb[ab] = ob ^ mb;
        exp_q.push_back('{a: 9'(ab), d: ob ^ mb});
      end
    end
  endtask

  task automatic issue(input logic op, input logic [6:0] x, input logic [5:0] y,
                       input logic [3:0] n, input logic [11:0] i);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_x     = x;
    cif.cmd_y     = y;
    cif.cmd_n     = n;
    cif.cmd_i     = i;
  endtask

  task automatic run_cmd(input string name, input logic op, input logic [6:0] x,
                         input logic [5:0] y, input logic [3:0] n, input logic [11:0] i);
    logic ec;
    int   rows, fetches, lat, k;
    model_cmd(op, x, y, n, i, 16, ec, rows, fetches);
    if (op == OP_CLS)    lat = 513;
    else if (n == 4'd0)
`ifdef SCHIP_SPRITE16_EN
      lat = 97;
`else
      lat = 1;
`endif
    else                 lat = 5 * int'(n) + 1;
    @(negedge clk);
    check_eq({name, "_ready"}, 32'(cif.cmd_ready), 1);
    issue(op, x, y, n, i);
    mem_cnt = 0;
    fb_cnt  = 0;
    @(posedge clk);
    for (k = 1; k <= lat + 5; k++) begin
      @(negedge clk);
      if (k == 1) cif.cmd_valid = 1'b0;
      if (cif.done) break;
    end
    check_eq({name, "_lat"}, 32'(k), 32'(lat));
    check_eq({name, "_coll"}, 32'(cif.collision), 32'(ec));
    check_eq({name, "_qleft"}, exp_q.size(), 0);
    check_eq({name, "_fbcnt"}, 32'(fb_cnt), (op == OP_CLS) ? 32'd512 : 32'(4 * rows));
    check_eq({name, "_memcnt"}, 32'(mem_cnt), 32'(rows * fetches));
    @(negedge clk);
    check_eq({name, "_donepulse"}, 32'(cif.done), 0);
  endtask

  initial begin
    logic ec;
    int   rows, fetches, mism;
    bit   saw_done;

    reset = 1'b1;
    fill  = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op = 1'b0;
    cif.cmd_x = '0;
    cif.cmd_y = '0;
    cif.cmd_n = '0;
    cif.cmd_i = '0;
    for (int k = 0; k < 4096; k++) mem[k] = 8'((k * 37 + 5) & 8'hFF);
    mem[12'h300] = 8'hF0;
    mem[12'h310] = 8'hFF;
    mem[12'h311] = 8'hFF;
    for (int k = 0; k < 512; k++) mfb[k] = 16'hFFFF;

    @(posedge clk);
    @(negedge clk);
    fill = 1'b0;
    check_eq("rst_ready", 32'(cif.cmd_ready), 1);
    check_eq("rst_done", 32'(cif.done), 0);
    check_eq("rst_coll", 32'(cif.collision), 0);
    check_eq("rst_mem_rd", 32'(mem_rd), 0);
    check_eq("rst_fbuf_en", 32'(fbuf_en), 0);
    check_eq("rst_fbuf_wr", 32'(fbuf_write), 0);
    check_eq("rst_addrs", {8'(mem_addr), 9'(fbuf_addr), 15'd0}, 0);
    check_eq("rst_fbuf_in", 32'(fbuf_in), 0);
    @(negedge clk);
    reset = 1'b0;

    run_cmd("cls", OP_CLS, 7'd0, 6'd0, 4'd0, 12'h000);
    check_eq("cls_w0", 32'(ram[0]), 0);
    check_eq("cls_w511", 32'(ram[511]), 0);

    run_cmd("drw1", OP_DRW, 7'd4, 6'd0, 4'd1, 12'h300);
    check_eq("drw1_w0", 32'(ram[0]), 32'h0F00);
    check_eq("drw1_w1", 32'(ram[1]), 0);

    run_cmd("drw2", OP_DRW, 7'd4, 6'd0, 4'd1, 12'h300);
    check_eq("erase_w0", 32'(ram[0]), 0);
    check_eq("erase_coll", 32'(cif.collision), 1);

    run_cmd("wrap", OP_DRW, 7'd124, 6'd63, 4'd2, 12'h310);
    check_eq("wrap_r63w7", 32'(ram[63*8+7]), 32'h000F);
    check_eq("wrap_r63w0", 32'(ram[63*8+0]), 32'hF000);
    check_eq("wrap_r0w7", 32'(ram[7]), 32'h000F);
    check_eq("wrap_r0w0", 32'(ram[0]), 32'hF000);
    check_eq("wrap_coll", 32'(cif.collision), 0);

    // Reset during RDB of row 1 of a 3-row draw: only row 0 lands.
    model_cmd(OP_DRW, 7'd20, 6'd10, 4'd3, 12'h320, 1, ec, rows, fetches);
    @(negedge clk);
    issue(OP_DRW, 7'd20, 6'd10, 4'd3, 12'h320);
    @(posedge clk);
    saw_done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) cif.cmd_valid = 1'b0;
      if (cif.done) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstmid_ready", 32'(cif.cmd_ready), 1);
    check_eq("rstmid_fbuf_en", 32'(fbuf_en), 0);
    check_eq("rstmid_done", 32'(cif.done | saw_done), 0);
    check_eq("rstmid_qleft", exp_q.size(), 0);
    reset = 1'b0;

    run_cmd("n0", OP_DRW, 7'd30, 6'd5, 4'd0, 12'h330);
    run_cmd("big", OP_DRW, 7'd9, 6'd40, 4'd15, 12'h200);
    run_cmd("iwrap", OP_DRW, 7'd127, 6'd60, 4'd7, 12'hFFC);

    mism = 0;
    for (int k = 0; k < 512; k++) if (ram[k] !== mfb[k]) mism++;
    check_eq("fb_final", 32'(mism), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
